// File: rtl/lsu_ctrl.sv
// Handshaked load/store controller: lane alignment, byte strobes, load extension, bus error/timeout.
// Define LSU_MISALIGN_TRAP_EN to trap misaligned requests; otherwise they are aligned down.
module lsu_ctrl #(
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_vld_i,
   output logic              req_rdy_o,
   input  logic              req_load_i,
   input  logic              req_store_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_sign_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_vld_o,
   output logic [DATA_W-1:0] rsp_data_o,
   output logic [1:0]        rsp_exc_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W/8-1:0] mem_be_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   input  logic              mem_gnt_i,
   input  logic              mem_rvld_i,
   input  logic [DATA_W-1:0] mem_rdata_i,
   input  logic              mem_err_i
);

   localparam int unsigned NB  = DATA_W / 8;
   localparam int unsigned OFS = $clog2(NB);
   localparam int unsigned CW  = $clog2(TIMEOUT + 1);

   localparam logic [1:0] EXC_OK    = 2'b00;
   localparam logic [1:0] EXC_ILL   = 2'b01;
   localparam logic [1:0] EXC_BUS   = 2'b10;
   localparam logic [1:0] EXC_TMOUT = 2'b11;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t state, state_nxt;

   logic [CW-1:0]     cnt, cnt_nxt, cnt_inc;
   logic              expired;

   logic              op_store;
   logic [1:0]        size_q;
   logic              sign_q;
   logic [OFS-1:0]    ofs_q;
   logic [ADDR_W-1:0] addr_q;
   logic [NB-1:0]     be_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rsp_data_q;
   logic [1:0]        rsp_exc_q;

   logic              accept, size_bad, illegal;
   logic [OFS-1:0]    ofs_raw, amask, ofs_use;
   logic [NB-1:0]     bmask;

   logic [DATA_W-1:0] shifted, ext;
   logic              sbit;
   int unsigned       nbits;

   // Request decode: alignment mask, strobe pattern and legality.
   always_comb begin
      ofs_raw = req_addr_i[OFS-1:0];
      amask   = '0;
      for (int unsigned i = 0; i < OFS; i++) begin
         amask[i] = (i < 32'(req_size_i));
      end
      bmask = '0;
      for (int unsigned i = 0; i < NB; i++) begin
         bmask[i] = (i < (32'd1 << req_size_i));
      end
      size_bad = (DATA_W == 32) && (req_size_i == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
      ofs_use = ofs_raw;
      illegal = size_bad | (|(ofs_raw & amask));
`else
      ofs_use = ofs_raw & ~amask;
      illegal = size_bad;
`endif
      accept = (state == IDLE) & req_vld_i & (req_load_i ^ req_store_i);
   end

   // Load extraction: shift selected lane down, then sign/zero-extend from the top selected bit.
   always_comb begin
      shifted = mem_rdata_i >> {ofs_q, 3'b000};
      nbits   = 32'd8 << size_q;
      sbit    = 1'b0;
      for (int unsigned b = 0; b < DATA_W; b++) begin
         if (b + 1 == nbits) sbit = shifted[b];
      end
      ext = '0;
      for (int unsigned b = 0; b < DATA_W; b++) begin
         ext[b] = (b < nbits) ? shifted[b] : (sign_q & sbit);
      end
   end

   assign cnt_inc = cnt + 1'b1;
   assign expired = (cnt_inc == CW'(TIMEOUT));

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (accept) state_nxt = illegal ? RESP : REQ;
         end
         REQ: begin
            if (mem_gnt_i) begin
               state_nxt = WAIT;
               cnt_nxt   = '0;
            end
         end
         WAIT: begin
            cnt_nxt = cnt_inc;
            if (mem_rvld_i || expired) state_nxt = RESP;
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_store   <= 1'b0;
         size_q     <= '0;
         sign_q     <= 1'b0;
         ofs_q      <= '0;
         addr_q     <= '0;
         be_q       <= '0;
         wdata_q    <= '0;
         rsp_data_q <= '0;
         rsp_exc_q  <= EXC_OK;
      end else begin
         if (accept) begin
            op_store <= req_store_i;
            size_q   <= req_size_i;
            sign_q   <= req_sign_i;
            ofs_q    <= ofs_use;
            addr_q   <= {req_addr_i[ADDR_W-1:OFS], {OFS{1'b0}}};
            be_q     <= bmask << ofs_use;
            wdata_q  <= req_wdata_i << {ofs_use, 3'b000};
            if (illegal) begin
               rsp_data_q <= '0;
               rsp_exc_q  <= EXC_ILL;
            end
         end
         // A response arriving on the expiry cycle wins over the timeout.
         if (state == WAIT) begin
            if (mem_rvld_i) begin
               rsp_exc_q  <= mem_err_i ? EXC_BUS : EXC_OK;
               rsp_data_q <= (mem_err_i | op_store) ? '0 : ext;
            end else if (expired) begin
               rsp_exc_q  <= EXC_TMOUT;
               rsp_data_q <= '0;
            end
         end
      end
   end

   assign req_rdy_o   = (state == IDLE);
   assign mem_req_o   = (state == REQ);
   assign mem_we_o    = (state == REQ) & op_store;
   assign rsp_vld_o   = (state == RESP);
   assign mem_addr_o  = addr_q;
   assign mem_be_o    = be_q;
   assign mem_wdata_o = wdata_q;
   assign rsp_data_o  = rsp_data_q;
   assign rsp_exc_o   = rsp_exc_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl (DATA_W=32, TIMEOUT=4): directed requests, monitor checks responses.
module tb_lsu_ctrl;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned TO = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          req_vld_i, req_rdy_o, req_load_i, req_store_i, req_sign_i;
   logic [1:0]    req_size_i;
   logic [AW-1:0] req_addr_i;
   logic [DW-1:0] req_wdata_i;
   logic          rsp_vld_o;
   logic [DW-1:0] rsp_data_o;
   logic [1:0]    rsp_exc_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [3:0]    mem_be_o;
   logic [DW-1:0] mem_wdata_o;
   logic          mem_gnt_i, mem_rvld_i, mem_err_i;
   logic [DW-1:0] mem_rdata_i;

   always #5 clk = ~clk;

   lsu_ctrl #(.DATA_W(DW), .ADDR_W(AW), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .req_vld_i(req_vld_i), .req_rdy_o(req_rdy_o), .req_load_i(req_load_i),
      .req_store_i(req_store_i), .req_size_i(req_size_i), .req_sign_i(req_sign_i),
      .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
      .rsp_vld_o(rsp_vld_o), .rsp_data_o(rsp_data_o), .rsp_exc_o(rsp_exc_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
      .mem_rvld_i(mem_rvld_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i)
   );

   int          total = 0;
   int          bad   = 0;
   int unsigned cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [31:0] data;
      logic [1:0]  exc;
      int unsigned at;
      string       name;
   } exp_t;

   exp_t sb[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   // Monitor: every response pulse must match the oldest expectation, including its cycle.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (rsp_vld_o === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_rsp: got rsp_vld=1 data=%h exc=%b want no response",
                     rsp_data_o, rsp_exc_o);
         end else begin
            e = sb.pop_front();
            chk({e.name, "_data"}, rsp_data_o, e.data);
            chk({e.name, "_exc"}, rsp_exc_o, e.exc);
            chk({e.name, "_cycle"}, cyc, e.at);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_bus();
      mem_gnt_i   = 1'b0;
      mem_rvld_i  = 1'b0;
      mem_err_i   = 1'b0;
      mem_rdata_i = '0;
   endtask

   // Latency is counted in cycles from the accept cycle (index 0).
   task automatic issue(input string name, input logic ld, input logic st, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd,
                        input bit push, input logic [31:0] edata, input logic [1:0] eexc,
                        input int unsigned lat);
      chk({name, "_rdy"}, req_rdy_o, 1);
      req_vld_i   = 1'b1;
      req_load_i  = ld;
      req_store_i = st;
      req_size_i  = sz;
      req_sign_i  = sg;
      req_addr_i  = a;
      req_wdata_i = wd;
      if (push) sb.push_back('{data: edata, exc: eexc, at: cyc + lat, name: name});
      tick();
      req_vld_i   = 1'b0;
      req_load_i  = 1'b0;
      req_store_i = 1'b0;
   endtask

   task automatic bus_xact(input logic [31:0] rdata, input logic err);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i   = 1'b0;
      mem_rvld_i  = 1'b1;
      mem_rdata_i = rdata;
      mem_err_i   = err;
      tick();
      idle_bus();
      tick();
   endtask

   initial begin
      rst         = 1'b1;
      req_vld_i   = 1'b0;
      req_load_i  = 1'b0;
      req_store_i = 1'b0;
      req_size_i  = 2'b00;
      req_sign_i  = 1'b0;
      req_addr_i  = '0;
      req_wdata_i = '0;
      idle_bus();
      tick();
      tick();
      chk("rst_rdy", req_rdy_o, 1);
      chk("rst_req", mem_req_o, 0);
      chk("rst_we", mem_we_o, 0);
      chk("rst_rsp_vld", rsp_vld_o, 0);
      chk("rst_addr", mem_addr_o, 0);
      chk("rst_be", mem_be_o, 0);
      chk("rst_wdata", mem_wdata_o, 0);
      chk("rst_rsp_data", rsp_data_o, 0);
      chk("rst_exc", rsp_exc_o, 0);
      rst = 1'b0;
      tick();

      // Signed byte load from the top lane.
      issue("sbyte", 1, 0, 2'b00, 1, 32'h0000_1003, 32'h0, 1, 32'hFFFF_FF80, 2'b00, 3);
      chk("sbyte_req", mem_req_o, 1);
      chk("sbyte_we", mem_we_o, 0);
      chk("sbyte_be", mem_be_o, 4'b1000);
      chk("sbyte_addr", mem_addr_o, 32'h0000_1000);
      bus_xact(32'h80FF_0000, 0);

      // Half store with five cycles of grant stall.
      issue("hstore", 0, 1, 2'b01, 0, 32'h0000_2002, 32'h0000_BEEF, 1, 32'h0, 2'b00, 8);
      for (int i = 0; i < 5; i++) begin
         chk("stall_req", mem_req_o, 1);
         chk("stall_we", mem_we_o, 1);
         chk("stall_addr", mem_addr_o, 32'h0000_2000);
         chk("stall_be", mem_be_o, 4'b1100);
         chk("stall_wdata", mem_wdata_o, 32'hBEEF_0000);
         chk("stall_rdy", req_rdy_o, 0);
         tick();
      end
      bus_xact(32'hDEAD_BEEF, 0);

      issue("bstore", 0, 1, 2'b00, 0, 32'h0000_5001, 32'h0000_00AB, 1, 32'h0, 2'b00, 3);
      chk("bstore_be", mem_be_o, 4'b0010);
      chk("bstore_wdata", mem_wdata_o, 32'h0000_AB00);
      bus_xact(32'h0, 0);

      issue("uhalf", 1, 0, 2'b01, 0, 32'h0000_6002, 32'h0, 1, 32'h0000_8123, 2'b00, 3);
      bus_xact(32'h8123_4567, 0);
      issue("shalf", 1, 0, 2'b01, 1, 32'h0000_6000, 32'h0, 1, 32'hFFFF_8765, 2'b00, 3);
      bus_xact(32'h1234_8765, 0);

`ifdef LSU_MISALIGN_TRAP_EN
      issue("misal", 1, 0, 2'b10, 0, 32'h0000_3002, 32'h0, 1, 32'h0, 2'b01, 1);
      chk("misal_noreq", mem_req_o, 0);
      tick();
      chk("misal_noreq2", mem_req_o, 0);
`else
      issue("misal", 1, 0, 2'b10, 0, 32'h0000_3002, 32'h0, 1, 32'hCAFE_BABE, 2'b00, 3);
      chk("misal_addr", mem_addr_o, 32'h0000_3000);
      chk("misal_be", mem_be_o, 4'b1111);
      bus_xact(32'hCAFE_BABE, 0);
`endif

      // Dword on a 32-bit bus is always illegal.
      issue("dword", 1, 0, 2'b11, 0, 32'h0000_8000, 32'h0, 1, 32'h0, 2'b01, 1);
      chk("dword_noreq", mem_req_o, 0);
      tick();
      chk("dword_noreq2", mem_req_o, 0);

      // Neither/both op bits: not accepted.
      req_vld_i   = 1'b1;
      req_load_i  = 1'b1;
      req_store_i = 1'b1;
      tick();
      chk("both_rdy", req_rdy_o, 1);
      chk("both_noreq", mem_req_o, 0);
      req_load_i  = 1'b0;
      req_store_i = 1'b0;
      tick();
      chk("none_rdy", req_rdy_o, 1);
      chk("none_noreq", mem_req_o, 0);
      req_vld_i = 1'b0;
      tick();

      issue("tmout", 1, 0, 2'b10, 0, 32'h0000_4000, 32'h0, 1, 32'h0, 2'b11, 6);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("tmout_rdy", req_rdy_o, 0);
         chk("tmout_noreq", mem_req_o, 0);
         tick();
      end
      tick();

      // Response on the expiry cycle beats the timeout.
      issue("edge", 1, 0, 2'b10, 0, 32'h0000_4004, 32'h0, 1, 32'h1122_3344, 2'b00, 6);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      repeat (3) tick();
      mem_rvld_i  = 1'b1;
      mem_rdata_i = 32'h1122_3344;
      tick();
      idle_bus();
      tick();

      issue("buserr", 1, 0, 2'b10, 1, 32'h0000_4008, 32'h0, 1, 32'h0, 2'b10, 3);
      bus_xact(32'hFFFF_FFFF, 1);

      // Reset while waiting, then a stray response.
      issue("rstwait", 1, 0, 2'b10, 0, 32'h0000_9000, 32'h0, 0, 32'h0, 2'b00, 0);
      mem_gnt_i = 1'b1;
      tick();
      mem_gnt_i = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("arst_rdy", req_rdy_o, 1);
      chk("arst_req", mem_req_o, 0);
      chk("arst_we", mem_we_o, 0);
      chk("arst_rsp_vld", rsp_vld_o, 0);
      chk("arst_addr", mem_addr_o, 0);
      chk("arst_be", mem_be_o, 0);
      chk("arst_rsp_data", rsp_data_o, 0);
      chk("arst_exc", rsp_exc_o, 0);
      tick();
      rst = 1'b0;
      mem_rvld_i  = 1'b1;
      mem_rdata_i = 32'h5555_AAAA;
      tick();
      tick();
      idle_bus();
      chk("stray_no_rsp", rsp_vld_o, 0);
      tick();
      chk("stray_no_rsp2", rsp_vld_o, 0);
      tick();

      chk("sb_drained", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Parametrised, handshaked load/store controller; next generation of the combinational load/store alignment logic.
- Sits between the execute/memory pipeline stage and the data-memory bus.
- Accepts one load or store request at a time, drives byte strobes and lane-aligned store data, and waits for the bus response.
- Returns sign/zero-extended load data or a store acknowledge; raises an exception on illegal size, bus error or response timeout.

Parameters:
DATA_W, 32, data bus width in bits; 32 or 64. NB = DATA_W/8 byte lanes, OFS = log2(NB).
ADDR_W, 32, address width.
TIMEOUT, 255, maximum cycles in WAIT before a timeout exception; must be at least 1.

Ports:
clk  input  1  clock
rst  input  1  reset; asynchronous assert, active-high
req_vld_i  input  1  request valid
req_rdy_o  output  1  request ready
req_load_i  input  1  load request
req_store_i  input  1  store request
req_size_i  input  2  00 byte, 01 half, 10 word, 11 dword
req_sign_i  input  1  1 = sign-extend load result
req_addr_i  input  ADDR_W  byte address
req_wdata_i  input  DATA_W  store data, right-justified
rsp_vld_o  output  1  response valid, one-cycle pulse
rsp_data_o  output  DATA_W  extended load data; 0 for stores
rsp_exc_o  output  2  00 ok, 01 misalign/illegal, 10 bus error, 11 timeout
mem_req_o  output  1  bus request
mem_we_o  output  1  bus write enable
mem_addr_o  output  ADDR_W  lane-aligned address (low OFS bits 0)
mem_be_o  output  NB  byte strobes
mem_wdata_o  output  DATA_W  lane-shifted store data
mem_gnt_i  input  1  bus grant
mem_rvld_i  input  1  response valid (load data or store ack)
mem_rdata_i  input  DATA_W  raw read data
mem_err_i  input  1  bus error, qualified by mem_rvld_i

Behaviour:
- Clocking: one clock, clk. rst is asynchronous, active-high.
- Reset:
  - State = IDLE.
  - req_rdy_o = 1.
  - mem_req_o, mem_we_o, rsp_vld_o = 0.
  - mem_addr_o, mem_be_o, mem_wdata_o, rsp_data_o, rsp_exc_o = 0.
  - Timeout counter = 0.
  - Asserting rst mid-transaction abandons it. Any late mem_rvld_i after reset is ignored in IDLE.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - req_rdy_o = 1.
  - Accept when req_vld_i & (req_load_i ^ req_store_i). Neither or both set: request is ignored and not accepted.
  - On accept, register op, size, sign, offset = addr[OFS-1:0], mem_be_o, mem_wdata_o and mem_addr_o.
  - Illegal request: size 11 with DATA_W=32, or offset not a multiple of 2^size. Go to RESP with exc 01; no bus access.
  - Otherwise go to REQ.
- REQ:
  - mem_req_o = 1; mem_we_o = store.
  - Hold all bus outputs stable until mem_gnt_i.
  - On grant, go to WAIT and clear the counter.
- WAIT:
  - mem_req_o = 0; counter increments each cycle.
  - mem_rvld_i: latch the response and go to RESP. exc = 10 if mem_err_i.
  - Counter reaches TIMEOUT without mem_rvld_i: go to RESP with exc 11.
  - mem_rvld_i in the same cycle as expiry takes priority over the timeout.
- RESP:
  - rsp_vld_o = 1 for exactly one cycle, then IDLE.
  - req_rdy_o = 0 in REQ, WAIT and RESP.
- Strobes: mem_be_o = ((1<<(2^size))-1) << offset. Store data is req_wdata_i shifted left by 8*offset.
- Load data: select bytes mem_rdata_i >> 8*offset, truncate to 2^size bytes. Sign-extend from the top selected bit if sign=1, else zero-extend. Exceptions force rsp_data_o = 0.
- Latency: with mem_gnt_i in the first REQ cycle and mem_rvld_i in the following cycle, rsp_vld_o rises 3 cycles after the accept edge. Illegal requests respond 1 cycle after accept.
- mem_rvld_i outside WAIT is ignored.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined: misaligned requests take the illegal path (exc 01, no bus access).
- Undefined: misaligned requests are silently aligned down. The offset is masked to a multiple of 2^size and the access proceeds normally. Only size 11 with DATA_W=32 still raises exc 01.

Test Plan:
- Signed byte load (DATA_W=32): addr 0x1003, sign=1; bus returns 0x80FF_0000 one cycle after grant -> mem_be_o=4'b1000, mem_addr_o=0x1000, rsp_data_o=0xFFFF_FF80, exc 00, rsp_vld_o 3 cycles after accept.
- Half store: addr 0x2002, wdata 0x0000_BEEF -> mem_we_o=1, mem_be_o=4'b1100, mem_wdata_o=0xBEEF_0000; ack -> rsp_data_o=0, exc 00.
- Grant stall: mem_gnt_i held low 5 cycles -> mem_req_o held with stable addr/be/wdata, req_rdy_o=0 throughout.
- Word load at addr 0x3002: with LSU_MISALIGN_TRAP_EN -> exc 01, mem_req_o never asserted. Without it -> access to 0x3000 with mem_be_o=4'b1111.
- TIMEOUT=4, no mem_rvld_i -> rsp_exc_o=11 after 4 WAIT cycles. A later mem_err_i response -> exc 10, rsp_data_o=0.
- rst asserted in WAIT -> all outputs 0 immediately; a later stray mem_rvld_i produces no rsp_vld_o.
